// File: rtl/inst_buffer.sv
// Fetch-to-decode instruction buffer: a circular FIFO filled by 1..4-word icache packets
// and drained one word per cycle toward decode.
module inst_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PTAB_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              icache_ns,
    input  logic [127:0]      icache_rd_data,
    input  logic [31:0]       icache_rd_pc,
    input  logic [PTAB_W-1:0] icache_ptab,
    input  logic              icache_delot_en,
    input  logic [31:0]       icache_branch_pc,
    output logic              ib_allin,
    output logic              ib_id_valid,
    output logic [31:0]       ib_id_inst,
    output logic [31:0]       ib_id_pc,
    output logic [PTAB_W-1:0] ib_id_ptab,
    output logic              ib_id_delot,
    output logic [31:0]       ib_id_branch_pc,
    input  logic              id_allin
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [31:0]       inst_q      [DEPTH];
    logic [31:0]       pc_q        [DEPTH];
    logic [31:0]       branch_pc_q [DEPTH];
    logic [PTAB_W-1:0] ptab_q      [DEPTH];
    logic [DEPTH-1:0]  delot_q;

    logic [1:0]    start_w;
    logic [2:0]    n_words;
    logic [AW:0]   free_slots;
    logic          wr_fire;
    logic          rd_fire;
    logic [3:0]    word_we;
    logic [AW-1:0] wr_idx [4];
    logic          unused_pc_lsb;

    assign unused_pc_lsb = ^icache_rd_pc[1:0];

    assign start_w    = icache_rd_pc[3:2];
    assign n_words    = 3'd4 - {1'b0, start_w};
    assign free_slots = DEPTH_C - count_q;

    // Room for a worst-case 4-word packet; deliberately ignores a same-cycle read.
    assign ib_allin    = reset & ~flush & (free_slots >= (AW + 1)'(4));
    assign ib_id_valid = (count_q != '0);

    assign wr_fire = icache_ns & ib_allin;
    assign rd_fire = ib_id_valid & id_allin;

    // Word k of the packet lands (k - start_w) slots past the write pointer.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            word_we[k] = wr_fire & (2'(k) >= start_w);
            wr_idx[k]  = wr_ptr_q + AW'(k) - AW'(start_w);
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(n_words);
            if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (wr_fire ? (AW + 1)'(n_words) : '0)
                              - (rd_fire ? (AW + 1)'(1) : '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            delot_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (word_we[k]) delot_q[wr_idx[k]] <= (k == 3) && icache_delot_en;
            end
        end
    end

    // Payload needs no reset: it is only observed while count_q marks it valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (word_we[k]) begin
                inst_q[wr_idx[k]]      <= icache_rd_data[32*k +: 32];
                pc_q[wr_idx[k]]        <= {icache_rd_pc[31:4], 2'(k), 2'b00};
                ptab_q[wr_idx[k]]      <= icache_ptab;
                branch_pc_q[wr_idx[k]] <= icache_branch_pc;
            end
        end
    end

    assign ib_id_inst      = inst_q[rd_ptr_q];
    assign ib_id_pc        = pc_q[rd_ptr_q];
    assign ib_id_ptab      = ptab_q[rd_ptr_q];
    assign ib_id_delot     = delot_q[rd_ptr_q];
    assign ib_id_branch_pc = branch_pc_q[rd_ptr_q];

endmodule
